sha256_krom_fetch: RTL and testbench

- Read-side controller for the 128x16 K-constant ROM macro (sky130 OpenROM, 7-bit address, registered inputs, data driven after the falling edge).
- Serves 32-bit SHA-256 round constants K[t], t=0..63, to the compression core over a valid/ready interface.
- Each K[t] takes two pipelined ROM reads: mem[2t]=K[t][31:16], mem[2t+1]=K[t][15:0].
- Supports single random-index fetch and a full 0..63 stream mode.

---
 rtl/sha256_krom_fetch.sv | 158 +++++++++++++++
 tb/tb_sha256_krom_fetch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_krom_fetch.sv
// Read-side controller for the 128x16 SHA-256 K-constant ROM macro.
// Each K[t] is fetched as two pipelined 16-bit reads (hi at 2t, lo at 2t+1) and presented over valid/ready.
module sha256_krom_fetch #(
    parameter int ROM_AW = 7,
    parameter int ROM_DW = 16,
    parameter int IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IDX_W-1:0]      req_idx,
    input  logic                  stream_start,
    output logic                  busy,
    output logic                  k_valid,
    input  logic                  k_ready,
    output logic [2*ROM_DW-1:0]   k_word,
    output logic [IDX_W-1:0]      k_idx,
    output logic                  k_last,
    output logic                  rom_cs,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [ROM_DW-1:0]     rom_dout
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_CAP  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t                state_r, state_s;
    logic [IDX_W-1:0]      idx_r, idx_s;
    logic                  stream_r, stream_s;
    logic [ROM_DW-1:0]     hi_r, hi_s;
    logic                  rom_cs_r, rom_cs_s;
    logic [ROM_AW-1:0]     rom_addr_r, rom_addr_s;
    logic                  k_valid_r, k_valid_s;
    logic [2*ROM_DW-1:0]   k_word_r, k_word_s;
    logic [IDX_W-1:0]      k_idx_r, k_idx_s;
    logic                  k_last_r, k_last_s;

    assign req_ready = (state_r == ST_IDLE) && !stream_start;
    assign busy      = (state_r != ST_IDLE);
    assign rom_cs    = rom_cs_r;
    assign rom_addr  = rom_addr_r;
    assign k_valid   = k_valid_r;
    assign k_word    = k_word_r;
    assign k_idx     = k_idx_r;
    assign k_last    = k_last_r;

    // Next-state and next-output logic; every register holds unless its state says otherwise.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        stream_s   = stream_r;
        hi_s       = hi_r;
        rom_cs_s   = rom_cs_r;
        rom_addr_s = rom_addr_r;
        k_valid_s  = k_valid_r;
        k_word_s   = k_word_r;
        k_idx_s    = k_idx_r;
        k_last_s   = k_last_r;
        case (state_r)
            ST_IDLE: begin
                // stream_start wins over a concurrent request, which stays pending
                if (stream_start) begin
                    stream_s   = 1'b1;
                    idx_s      = IDX_ZERO;
                    rom_cs_s   = 1'b1;
                    rom_addr_s = {IDX_ZERO, 1'b0};
                    state_s    = ST_HI;
                end else if (req_valid) begin
                    stream_s   = 1'b0;
                    idx_s      = req_idx;
                    rom_cs_s   = 1'b1;
                    rom_addr_s = {req_idx, 1'b0};
                    state_s    = ST_HI;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_HI: begin
                rom_addr_s = {idx_r, 1'b1};
                state_s    = ST_LO;
            end
            ST_LO: begin
                // hi half captured by the ROM last edge is valid now
                hi_s     = rom_dout;
                rom_cs_s = 1'b0;
                state_s  = ST_CAP;
            end
            ST_CAP: begin
                k_word_s  = {hi_r, rom_dout};
                k_idx_s   = idx_r;
                k_last_s  = stream_r && (idx_r == IDX_LAST);
                k_valid_s = 1'b1;
                state_s   = ST_OUT;
            end
            ST_OUT: begin
                if (k_ready) begin
                    k_valid_s = 1'b0;
                    if (stream_r && (idx_r != IDX_LAST)) begin
                        idx_s      = idx_r + IDX_ONE;
                        rom_cs_s   = 1'b1;
                        rom_addr_s = {idx_r + IDX_ONE, 1'b0};
                        state_s    = ST_HI;
                    end else begin
                        stream_s = 1'b0;
                        k_last_s = 1'b0;
                        state_s  = ST_IDLE;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                rom_cs_s  = 1'b0;
                k_valid_s = 1'b0;
                stream_s  = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; an in-flight word is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_ZERO;
            stream_r   <= 1'b0;
            hi_r       <= {ROM_DW{1'b0}};
            rom_cs_r   <= 1'b0;
            rom_addr_r <= {ROM_AW{1'b0}};
            k_valid_r  <= 1'b0;
            k_word_r   <= {(2*ROM_DW){1'b0}};
            k_idx_r    <= IDX_ZERO;
            k_last_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            stream_r   <= stream_s;
            hi_r       <= hi_s;
            rom_cs_r   <= rom_cs_s;
            rom_addr_r <= rom_addr_s;
            k_valid_r  <= k_valid_s;
            k_word_r   <= k_word_s;
            k_idx_r    <= k_idx_s;
            k_last_r   <= k_last_s;
        end
    end

endmodule

// File: tb/tb_sha256_krom_fetch.sv
// Directed bench for sha256_krom_fetch with a behavioural 128x16 K ROM and an output scoreboard.
module tb_sha256_krom_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_idx;
    logic        stream_start;
    logic        busy;
    logic        k_valid;
    logic        k_ready;
    logic [31:0] k_word;
    logic [5:0]  k_idx;
    logic        k_last;
    logic        rom_cs;
    logic [6:0]  rom_addr;
    logic [15:0] rom_dout;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int last_hs = 0;
    bit spacing_en = 1'b0;

    typedef struct packed {
        logic [31:0] w;
        logic [5:0]  i;
        logic        l;
    } exp_t;
    exp_t exp_q[$];
    logic [6:0] rom_log[$];

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic [15:0] rom_mem [128];

    sha256_krom_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_idx      (req_idx),
        .stream_start (stream_start),
        .busy         (busy),
        .k_valid      (k_valid),
        .k_ready      (k_ready),
        .k_word       (k_word),
        .k_idx        (k_idx),
        .k_last       (k_last),
        .rom_cs       (rom_cs),
        .rom_addr     (rom_addr),
        .rom_dout     (rom_dout)
    );

    always #5 clk = ~clk;

    // Cycle counter for handshake spacing.
    always @(posedge clk) cyc_cnt++;

    initial begin
        for (int t = 0; t < 64; t++) begin
            rom_mem[2*t]   = k_tab[t][31:16];
            rom_mem[2*t+1] = k_tab[t][15:0];
        end
    end

    // ROM model: captures cs/addr on posedge, drives data after the falling edge, X after hold.
    always @(posedge clk) begin
        logic       cap;
        logic [6:0] cap_addr;
        cap      = (rom_cs === 1'b1);
        cap_addr = rom_addr;
        if (cap) rom_log.push_back(cap_addr);
        #1 rom_dout = 16'hxxxx;
        @(negedge clk);
        if (cap) rom_dout = rom_mem[cap_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int t, input logic last);
        exp_q.push_back({k_tab[t], 6'(t), last});
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            if (exp_q.size() == 0 && busy === 1'b0) break;
            cyc();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_stream_log();
        chk("stream_rom_reads", 32'(rom_log.size()), 32'd128);
        for (int a = 0; a < 128 && a < rom_log.size(); a++)
            chk($sformatf("stream_rom_addr[%0d]", a), 32'(rom_log[a]), 32'(a));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rom_cs"},   32'(rom_cs),   32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_k_valid"},  32'(k_valid),  32'd0);
        chk({tag, "_k_word"},   k_word,        32'd0);
        chk({tag, "_k_idx"},    32'(k_idx),    32'd0);
        chk({tag, "_k_last"},   32'(k_last),   32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    // Scoreboard: pops one expected word per output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && k_valid === 1'b1 && k_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed idx %0d word %h expected no word", k_idx, k_word);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_word", k_word, e.w);
                chk("sb_idx", 32'(k_idx), 32'(e.i));
                chk("sb_last", 32'(k_last), 32'(e.l));
            end
            if (spacing_en && k_idx != 6'd0)
                chk("stream_spacing", 32'(cyc_cnt - last_hs), 32'd4);
            last_hs = cyc_cnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        rst = 1'b1; req_valid = 1'b0; req_idx = 6'd0; stream_start = 1'b0; k_ready = 1'b0;
        repeat (3) cyc();
        chk_reset_outs("reset");
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        cyc();

        // Single fetch t=0 with consumer always ready.
        rom_log.delete();
        req_valid = 1'b1; req_idx = 6'd0; k_ready = 1'b1;
        push_word(0, 1'b0);
        #1 chk("t0_req_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("t0_a1_cs", 32'(rom_cs), 32'd1);
        chk("t0_a1_addr", 32'(rom_addr), 32'd0);
        chk("t0_a1_busy", 32'(busy), 32'd1);
        cyc();
        chk("t0_a2_cs", 32'(rom_cs), 32'd1);
        chk("t0_a2_addr", 32'(rom_addr), 32'd1);
        chk("t0_a2_valid", 32'(k_valid), 32'd0);
        cyc();
        chk("t0_a3_cs", 32'(rom_cs), 32'd0);
        chk("t0_a3_addr", 32'(rom_addr), 32'd1);
        chk("t0_a3_valid", 32'(k_valid), 32'd0);
        cyc();
        chk("t0_valid", 32'(k_valid), 32'd1);
        chk("t0_word", k_word, 32'h428a2f98);
        chk("t0_idx", 32'(k_idx), 32'd0);
        chk("t0_last", 32'(k_last), 32'd0);
        cyc();
        chk("t0_done_valid", 32'(k_valid), 32'd0);
        chk("t0_done_busy", 32'(busy), 32'd0);
        chk("t0_rom_reads", 32'(rom_log.size()), 32'd2);
        if (rom_log.size() == 2) begin
            chk("t0_rom_hi", 32'(rom_log[0]), 32'd0);
            chk("t0_rom_lo", 32'(rom_log[1]), 32'd1);
        end

        // Single fetch t=63 with a 10-cycle stall.
        req_valid = 1'b1; req_idx = 6'd63; k_ready = 1'b0;
        push_word(63, 1'b0);
        cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
        for (int s = 0; s < 10; s++) begin
            chk("stall_valid", 32'(k_valid), 32'd1);
            chk("stall_word", k_word, 32'hc67178f2);
            chk("stall_cs", 32'(rom_cs), 32'd0);
            cyc();
        end
        k_ready = 1'b1;
        cyc();
        chk("stall_idle_busy", 32'(busy), 32'd0);
        chk("stall_idle_valid", 32'(k_valid), 32'd0);
        chk("stall_left", 32'(exp_q.size()), 32'd0);

        // Full stream with k_ready high.
        rom_log.delete();
        stream_start = 1'b1;
        for (int t = 0; t < 64; t++) push_word(t, t == 63);
        #1 chk("stream_req_ready_start", 32'(req_ready), 32'd0);
        cyc();
        stream_start = 1'b0;
        spacing_en = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            chk("stream_busy", 32'(busy), 32'd1);
            chk("stream_req_ready", 32'(req_ready), 32'd0);
            if (k_valid === 1'b1 && k_idx == 6'd63) begin
                done = 1'b1;
                cyc();
                chk("stream_end_busy", 32'(busy), 32'd0);
            end else begin
                cyc();
            end
        end
        chk("stream_reached_end", 32'(done), 32'd1);
        spacing_en = 1'b0;
        wait_drain(20);
        chk_stream_log();

        // stream_start and a request together: stream first, request afterwards.
        stream_start = 1'b1; req_valid = 1'b1; req_idx = 6'd5; k_ready = 1'b1;
        for (int t = 0; t < 64; t++) push_word(t, t == 63);
        push_word(5, 1'b0);
        #1 chk("prio_req_ready", 32'(req_ready), 32'd0);
        cyc();
        stream_start = 1'b0;
        chk("prio_busy", 32'(busy), 32'd1);
        done = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            cyc();
            if (req_ready === 1'b1) begin
                done = 1'b1;
                cyc();
                req_valid = 1'b0;
            end
        end
        chk("prio_req_accepted", 32'(done), 32'd1);
        wait_drain(40);

        // Stream with random backpressure.
        rom_log.delete();
        for (int t = 0; t < 64; t++) push_word(t, t == 63);
        stream_start = 1'b1;
        cyc();
        stream_start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0 && busy === 1'b0) break;
            k_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        k_ready = 1'b1;
        wait_drain(20);
        chk_stream_log();

        // Reset while in S_LO of a fetch for t=10: the word must never appear.
        req_valid = 1'b1; req_idx = 6'd10; k_ready = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk_reset_outs("midrst");
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            cyc();
            chk("midrst_no_valid", 32'(k_valid), 32'd0);
        end
        req_valid = 1'b1; req_idx = 6'd2;
        push_word(2, 1'b0);
        cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
        chk("midrst_t2_word", k_word, 32'hb5c0fbcf);
        chk("midrst_t2_valid", 32'(k_valid), 32'd1);
        wait_drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
